// File: rtl/axi_hub_n_if.sv
// rtl/axi_hub_n_if.sv - AXI-lite channel bundle for N ports, sliced per port
interface axi_hub_n_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int N_PORTS    = 1
);
  logic [N_PORTS*ADDR_WIDTH-1:0] awaddr;
  logic [N_PORTS-1:0]            awvalid;
  logic [N_PORTS-1:0]            awready;
  logic [N_PORTS*DATA_WIDTH-1:0] wdata;
  logic [N_PORTS-1:0]            wvalid;
  logic [N_PORTS-1:0]            wready;
  logic [N_PORTS*2-1:0]          bresp;
  logic [N_PORTS-1:0]            bvalid;
  logic [N_PORTS-1:0]            bready;
  logic [N_PORTS*ADDR_WIDTH-1:0] araddr;
  logic [N_PORTS-1:0]            arvalid;
  logic [N_PORTS-1:0]            arready;
  logic [N_PORTS*DATA_WIDTH-1:0] rdata;
  logic [N_PORTS*2-1:0]          rresp;
  logic [N_PORTS-1:0]            rvalid;
  logic [N_PORTS-1:0]            rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_hub_n.sv
// rtl/axi_hub_n.sv - single-master, N-slave AXI-lite hub with top-address-bit decode
module axi_hub_n #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int N_SLAVES   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  axi_hub_n_if.slave  m,
  axi_hub_n_if.master s
);
  localparam int SEL_BITS = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  // One extra bit so N_SLAVES itself is representable in the range compare.
  localparam logic [SEL_BITS:0] N_SEL = (SEL_BITS + 1)'(N_SLAVES);

  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_ERRD, W_ERRB} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP, R_ERR} r_state_t;

  w_state_t              w_state, w_next;
  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] w_addr, r_addr;
  logic [SEL_BITS-1:0]   w_sel, r_sel;
  logic [SEL_BITS-1:0]   aw_sel, ar_sel;
  logic                  aw_sel_ok, ar_sel_ok;
  logic [N_SLAVES-1:0]   w_onehot, r_onehot;
  logic                  sel_awready, sel_wready, sel_bvalid;
  logic [1:0]            sel_bresp;
  logic                  sel_arready, sel_rvalid;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic [1:0]            sel_rresp;

  assign aw_sel    = m.awaddr[ADDR_WIDTH-1 -: SEL_BITS];
  assign ar_sel    = m.araddr[ADDR_WIDTH-1 -: SEL_BITS];
  assign aw_sel_ok = {1'b0, aw_sel} < N_SEL;
  assign ar_sel_ok = {1'b0, ar_sel} < N_SEL;

  // Address is broadcast; only the selected slave's valid qualifies it.
  assign s.awaddr = {N_SLAVES{w_addr}};
  assign s.wdata  = {N_SLAVES{m.wdata}};
  assign s.araddr = {N_SLAVES{r_addr}};

  // Select the captured slave's handshake and response signals for each direction.
  always_comb begin
    w_onehot    = '0;
    r_onehot    = '0;
    sel_awready = 1'b0;
    sel_wready  = 1'b0;
    sel_bvalid  = 1'b0;
    sel_bresp   = 2'b00;
    sel_arready = 1'b0;
    sel_rvalid  = 1'b0;
    sel_rdata   = '0;
    sel_rresp   = 2'b00;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (w_sel == SEL_BITS'(i)) begin
        w_onehot[i] = 1'b1;
        sel_awready = s.awready[i];
        sel_wready  = s.wready[i];
        sel_bvalid  = s.bvalid[i];
        sel_bresp   = s.bresp[2*i +: 2];
      end
      if (r_sel == SEL_BITS'(i)) begin
        r_onehot[i] = 1'b1;
        sel_arready = s.arready[i];
        sel_rvalid  = s.rvalid[i];
        sel_rdata   = s.rdata[DATA_WIDTH*i +: DATA_WIDTH];
        sel_rresp   = s.rresp[2*i +: 2];
      end
    end
  end

  // Write state register; address and slave index captured on the AW handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_sel   <= '0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && m.awvalid) begin
        w_addr <= m.awaddr;
        w_sel  <= aw_sel;
      end
    end
  end

  // Write next state and channel routing; W and B pass through combinationally.
  always_comb begin
    w_next    = w_state;
    m.awready = 1'b0;
    m.wready  = 1'b0;
    m.bvalid  = 1'b0;
    m.bresp   = 2'b00;
    s.awvalid = '0;
    s.wvalid  = '0;
    s.bready  = '0;
    case (w_state)
      W_IDLE: begin
        m.awready = rst_n;
        if (m.awvalid) w_next = aw_sel_ok ? W_ADDR : W_ERRD;
      end
      W_ADDR: begin
        s.awvalid = w_onehot;
        if (sel_awready) w_next = W_DATA;
      end
      W_DATA: begin
        s.wvalid = w_onehot & {N_SLAVES{m.wvalid}};
        m.wready = sel_wready;
        if (m.wvalid && sel_wready) w_next = W_RESP;
      end
      W_RESP: begin
        m.bvalid = sel_bvalid;
        m.bresp  = sel_bresp;
        s.bready = w_onehot & {N_SLAVES{m.bready}};
        if (sel_bvalid && m.bready) w_next = W_IDLE;
      end
      W_ERRD: begin
        m.wready = 1'b1;
        if (m.wvalid) w_next = W_ERRB;
      end
      W_ERRB: begin
        m.bvalid = 1'b1;
        m.bresp  = 2'b11;
        if (m.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Read state register; address and slave index captured on the AR handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && m.arvalid) begin
        r_addr <= m.araddr;
        r_sel  <= ar_sel;
      end
    end
  end

  // Read next state and channel routing; R passes through combinationally.
  always_comb begin
    r_next    = r_state;
    m.arready = 1'b0;
    m.rvalid  = 1'b0;
    m.rdata   = '0;
    m.rresp   = 2'b00;
    s.arvalid = '0;
    s.rready  = '0;
    case (r_state)
      R_IDLE: begin
        m.arready = rst_n;
        if (m.arvalid) r_next = ar_sel_ok ? R_ADDR : R_ERR;
      end
      R_ADDR: begin
        s.arvalid = r_onehot;
        if (sel_arready) r_next = R_RESP;
      end
      R_RESP: begin
        m.rvalid = sel_rvalid;
        m.rdata  = sel_rdata;
        m.rresp  = sel_rresp;
        s.rready = r_onehot & {N_SLAVES{m.rready}};
        if (sel_rvalid && m.rready) r_next = R_IDLE;
      end
      R_ERR: begin
        m.rvalid = 1'b1;
        m.rresp  = 2'b11;
        if (m.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_hub_n.sv
// tb/tb_axi_hub_n.sv - directed scoreboard bench for axi_hub_n with three slave models
module tb_axi_hub_n;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] r;
  } rd_exp_t;

  logic [1:0] wq[$];
  rd_exp_t    rq[$];

  logic [1:0] cfg_bresp[3];
  int         cfg_rwait[3];
  logic [7:0] cfg_rdata[3];
  logic [1:0] cfg_rresp[3];

  logic [3:0] slv_awaddr[3];
  logic [7:0] slv_wdata[3];
  int         slv_aw_cyc[3];
  int         vcnt[3];

  int c_aw, c_w, c_b, c_aw2, c_w2, c_b2, c_ar, c_r, vsum;

  axi_hub_n_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .N_PORTS(1)) m_if ();
  axi_hub_n_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .N_PORTS(3)) s_if ();

  axi_hub_n #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .N_SLAVES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m     (m_if),
    .s     (s_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, expected summary before timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave responders: zero-wait AW/W/AR readies, B one cycle after W, R after cfg_rwait.
  initial begin : slave_model
    logic [2:0] aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [2:0] r_pend;
    int         r_cnt[3];
    s_if.bvalid = '0; s_if.bresp = '0;
    s_if.rvalid = '0; s_if.rdata = '0; s_if.rresp = '0;
    r_pend = '0;
    for (int i = 0; i < 3; i++) begin
      vcnt[i] = 0; slv_aw_cyc[i] = -1; slv_awaddr[i] = '0; slv_wdata[i] = '0; r_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      aw_hs = s_if.awvalid & s_if.awready;
      w_hs  = s_if.wvalid  & s_if.wready;
      b_hs  = s_if.bvalid  & s_if.bready;
      ar_hs = s_if.arvalid & s_if.arready;
      r_hs  = s_if.rvalid  & s_if.rready;
      for (int i = 0; i < 3; i++) begin
        if (s_if.awvalid[i] || s_if.wvalid[i] || s_if.arvalid[i]) vcnt[i]++;
        if (aw_hs[i]) begin slv_awaddr[i] = s_if.awaddr[4*i +: 4]; slv_aw_cyc[i] = cyc; end
        if (w_hs[i]) slv_wdata[i] = s_if.wdata[8*i +: 8];
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (b_hs[i]) s_if.bvalid[i] = 1'b0;
        if (w_hs[i]) begin s_if.bvalid[i] = 1'b1; s_if.bresp[2*i +: 2] = cfg_bresp[i]; end
        if (r_hs[i]) s_if.rvalid[i] = 1'b0;
        if (ar_hs[i]) begin r_pend[i] = 1'b1; r_cnt[i] = cfg_rwait[i]; end
        if (r_pend[i]) begin
          if (r_cnt[i] == 0) begin
            s_if.rvalid[i] = 1'b1;
            s_if.rdata[8*i +: 8] = cfg_rdata[i];
            s_if.rresp[2*i +: 2] = cfg_rresp[i];
            r_pend[i] = 1'b0;
          end else r_cnt[i]--;
        end
      end
    end
  end

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic [1:0] exp_resp,
                          input int bhold, output int o_aw, output int o_w, output int o_b);
    logic       aw_hs, w_hs, done;
    int         held;
    logic [1:0] b0, e;
    wq.push_back(exp_resp);
    m_if.awaddr = a; m_if.awvalid = 1'b1;
    m_if.wdata = d;  m_if.wvalid = 1'b1;
    m_if.bready = (bhold == 0);
    aw_hs = 1'b0; w_hs = 1'b0; done = 1'b0; held = 0; b0 = '0;
    o_aw = -1; o_w = -1; o_b = -1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (m_if.awvalid && m_if.awready) begin aw_hs = 1'b1; o_aw = cyc; end
      if (m_if.wvalid && m_if.wready) begin w_hs = 1'b1; o_w = cyc; end
      if (m_if.bvalid) begin
        if (held == 0) begin b0 = m_if.bresp; chk("aw_blocked", m_if.awready, 0); end
        else chk("b_stable", m_if.bresp, b0);
        if (m_if.bready) begin
          e = wq.pop_front();
          chk("bresp", m_if.bresp, e);
          o_b = cyc; done = 1'b1;
        end
        held++;
      end
      @(posedge clk); #1;
      if (aw_hs) m_if.awvalid = 1'b0;
      if (w_hs) m_if.wvalid = 1'b0;
      if (held >= bhold) m_if.bready = 1'b1;
    end
    m_if.bready = 1'b0;
    if (!done) chk("b_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] exp_d, input logic [1:0] exp_r,
                         input int rhold, output int o_ar, output int o_r);
    logic       ar_hs, done;
    int         held;
    logic [9:0] r0;
    rd_exp_t    e;
    rq.push_back('{exp_d, exp_r});
    m_if.araddr = a; m_if.arvalid = 1'b1;
    m_if.rready = (rhold == 0);
    ar_hs = 1'b0; done = 1'b0; held = 0; r0 = '0; o_ar = -1; o_r = -1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (m_if.arvalid && m_if.arready) begin ar_hs = 1'b1; o_ar = cyc; end
      if (m_if.rvalid) begin
        if (held == 0) begin r0 = {m_if.rresp, m_if.rdata}; chk("ar_blocked", m_if.arready, 0); end
        else chk("r_stable", {m_if.rresp, m_if.rdata}, r0);
        if (m_if.rready) begin
          e = rq.pop_front();
          chk("rdata", m_if.rdata, e.d);
          chk("rresp", m_if.rresp, e.r);
          o_r = cyc; done = 1'b1;
        end
        held++;
      end
      @(posedge clk); #1;
      if (ar_hs) m_if.arvalid = 1'b0;
      if (held >= rhold) m_if.rready = 1'b1;
    end
    m_if.rready = 1'b0;
    if (!done) chk("r_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    m_if.awaddr = '0; m_if.awvalid = 1'b0; m_if.wdata = '0; m_if.wvalid = 1'b0; m_if.bready = 1'b0;
    m_if.araddr = '0; m_if.arvalid = 1'b0; m_if.rready = 1'b0;
    s_if.awready = '1; s_if.wready = '1; s_if.arready = '1;
    for (int i = 0; i < 3; i++) begin
      cfg_bresp[i] = 2'b00; cfg_rwait[i] = 0; cfg_rdata[i] = 8'h00; cfg_rresp[i] = 2'b00;
    end
    cfg_rdata[0] = 8'h5A;
    cfg_rdata[2] = 8'h3C; cfg_rwait[2] = 4;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_s_valid", {s_if.awvalid, s_if.wvalid, s_if.arvalid}, 0);
    chk("rst_s_ready", {s_if.bready, s_if.rready}, 0);
    chk("rst_m_valid", {m_if.bvalid, m_if.rvalid}, 0);
    chk("rst_m_resp", {m_if.bresp, m_if.rresp, m_if.rdata}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_awready", m_if.awready, 1);
    chk("rst_arready", m_if.arready, 1);
    @(posedge clk); #1;

    // Best-case write to slave 1, then back-to-back write
    do_write(4'h5, 8'hA5, 2'b00, 0, c_aw, c_w, c_b);
    chk("wr_s_aw_cycle", slv_aw_cyc[1] - c_aw, 1);
    chk("wr_s_awaddr", slv_awaddr[1], 4'h5);
    chk("wr_s_wdata", slv_wdata[1], 8'hA5);
    chk("wr_w_cycle", c_w - c_aw, 2);
    chk("wr_b_cycle", c_b - c_aw, 3);
    chk("wr_other_idle", vcnt[0] + vcnt[2], 0);
    do_write(4'h4, 8'h11, 2'b00, 0, c_aw2, c_w2, c_b2);
    chk("wr_b2b_aw", c_aw2 - c_b, 1);
    chk("wr_b2b_wdata", slv_wdata[1], 8'h11);

    // Read slave 2 with four wait cycles and five cycles of rready backpressure
    do_read(4'h9, 8'h3C, 2'b00, 5, c_ar, c_r);
    chk("rd_r_cycle", c_r - c_ar, 11);
    chk("rd_slave0_idle", vcnt[0], 0);

    // Decode errors
    vsum = vcnt[0] + vcnt[1] + vcnt[2];
    do_write(4'hC, 8'h99, 2'b11, 0, c_aw, c_w, c_b);
    chk("err_w_cycle", c_w - c_aw, 1);
    chk("err_b_cycle", c_b - c_aw, 2);
    do_read(4'hF, 8'h00, 2'b11, 0, c_ar, c_r);
    chk("err_r_cycle", c_r - c_ar, 1);
    chk("err_no_slave_valid", vcnt[0] + vcnt[1] + vcnt[2], vsum);

    // Concurrent write and read to slave 0
    fork
      do_write(4'h1, 8'h77, 2'b00, 0, c_aw, c_w, c_b);
      do_read(4'h2, 8'h5A, 2'b00, 0, c_ar, c_r);
    join
    chk("cc_same_cycle", c_ar - c_aw, 0);
    chk("cc_s_awaddr", slv_awaddr[0], 4'h1);
    chk("cc_s_wdata", slv_wdata[0], 8'h77);
    chk("cc_b_cycle", c_b - c_aw, 3);
    chk("cc_r_cycle", c_r - c_ar, 2);

    // Write backpressure on slave 2 carrying a slave error response
    cfg_bresp[2] = 2'b10;
    do_write(4'h8, 8'hE1, 2'b10, 5, c_aw, c_w, c_b);
    chk("bp_b_cycle", c_b - c_aw, 8);
    chk("bp_s_wdata", slv_wdata[2], 8'hE1);

    // Reset while the write FSM sits in W_DATA
    s_if.wready[1] = 1'b0;
    m_if.awaddr = 4'h7; m_if.awvalid = 1'b1; m_if.wdata = 8'hBE; m_if.wvalid = 1'b1; m_if.bready = 1'b1;
    @(negedge clk);
    chk("rs_aw_accept", m_if.awready, 1);
    @(posedge clk); #1;
    m_if.awvalid = 1'b0;
    @(negedge clk);
    chk("rs_s_awvalid", s_if.awvalid, 3'b010);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rs_s_wvalid", s_if.wvalid, 3'b010);
    rst_n = 1'b0;
    #1;
    chk("rs_s_valid_low", {s_if.awvalid, s_if.wvalid, s_if.arvalid}, 0);
    chk("rs_m_resp_low", {m_if.bvalid, m_if.wready}, 0);
    m_if.wvalid = 1'b0; m_if.bready = 1'b0;
    s_if.wready[1] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rs_awready", m_if.awready, 1);
    chk("rs_no_bvalid", m_if.bvalid, 0);
    @(posedge clk); #1;
    do_write(4'h6, 8'h42, 2'b00, 0, c_aw, c_w, c_b);
    chk("rs_wr_wdata", slv_wdata[1], 8'h42);
    chk("rs_wr_b_cycle", c_b - c_aw, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_hub_n.md
# axi_hub_n

Parametrised single-master, N-slave AXI-lite hub; successor to the fixed two-slave hub. Decodes the slave index from the top address bits, forwards single-beat write and read transactions to the selected slave through independent write and read state machines, and returns a decode error for indices at or above N_SLAVES. It sits between one master-side axi port and an array of slave-side axi ports in the system top.

## Interface
- ADDR_WIDTH, 4, address width; must be > SEL_BITS
- DATA_WIDTH, 8, data width
- N_SLAVES, 3, number of slave ports, 2..16
- SEL_BITS (localparam), max(1, $clog2(N_SLAVES)), slave index = addr[ADDR_WIDTH-1 -: SEL_BITS]

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m_awaddr / m_awvalid / m_awready  in/in/out  ADDR_WIDTH/1/1  master write address
- m_wdata / m_wvalid / m_wready  in/in/out  DATA_WIDTH/1/1  master write data
- m_bresp / m_bvalid / m_bready  out/out/in  2/1/1  master write response
- m_araddr / m_arvalid / m_arready  in/in/out  ADDR_WIDTH/1/1  master read address
- m_rdata / m_rresp / m_rvalid / m_rready  out/out/out/in  DATA_WIDTH/2/1/1  master read data
- s_awaddr / s_awvalid / s_awready  out/out/in  N*ADDR_WIDTH/N/N  slave write address, slice i = slave i
- s_wdata / s_wvalid / s_wready  out/out/in  N*DATA_WIDTH/N/N
- s_bresp / s_bvalid / s_bready  in/in/out  2N/N/N
- s_araddr / s_arvalid / s_arready  out/out/in  N*ADDR_WIDTH/N/N
- s_rdata / s_rresp / s_rvalid / s_rready  in/in/in/out  N*DATA_WIDTH/2N/N/N

## Operation
- Write FSM: W_IDLE, W_ADDR, W_DATA, W_RESP, W_ERRD, W_ERRB. Read FSM: R_IDLE, R_ADDR, R_RESP, R_ERR. The two FSMs are fully independent; concurrent read and write to the same slave allowed.
- W_IDLE: m_awready=1, m_wready=0. On AW handshake register awaddr and sel; sel < N_SLAVES -> W_ADDR, else -> W_ERRD.
- W_ADDR: s_awvalid[sel]=1, s_awaddr all slices = registered addr. On s_awready[sel] -> W_DATA.
- W_DATA: s_wvalid[sel]=m_wvalid, m_wready=s_wready[sel], s_wdata all slices = m_wdata (combinational). On handshake -> W_RESP.
- W_RESP: m_bvalid=s_bvalid[sel], m_bresp=s_bresp[sel], s_bready[sel]=m_bready. On handshake -> W_IDLE.
- W_ERRD: m_wready=1, data discarded; on W handshake -> W_ERRB. W_ERRB: m_bvalid=1, m_bresp=2'b11; on m_bready -> W_IDLE.
- R_IDLE: m_arready=1; capture araddr/sel; valid sel -> R_ADDR, else -> R_ERR.
- R_ADDR: s_arvalid[sel]=1 until s_arready[sel] -> R_RESP.
- R_RESP: m_rvalid/m_rdata/m_rresp = slave sel's; s_rready[sel]=m_rready; on handshake -> R_IDLE.
- R_ERR: m_rvalid=1, m_rdata=0, m_rresp=2'b11; on m_rready -> R_IDLE.
- Non-selected slaves: all valid/ready outputs 0. Non-selected master-facing handshakes 0 outside the states above.
- One outstanding transaction per direction; single-beat only.

## Timing
- Reset (rst_n low, asynchronous): both FSMs to IDLE; all s_*valid, s_*ready = 0; m_bvalid=m_rvalid=0; m_bresp=m_rresp=0, m_rdata=0; m_awready=m_arready=1 once rst_n high. Reset mid-transaction abandons it; no response issued.
- Best-case write: AW handshake cycle 0, s_awvalid cycle 1, W handshake cycle 2, B handshake cycle 3 (zero-wait slave). Back-to-back: next AW accepted cycle 4.
- Best-case read: AR cycle 0, s_arvalid cycle 1, R handshake cycle 2; next AR cycle 3.
- Decode error write: AW cycle 0, W cycle 1, bvalid cycle 2. Read: AR cycle 0, rvalid cycle 1.
- W/B/R paths are combinational through the hub (no added cycle); AW/AR add one registered cycle.
- Valid signals driven by the hub never drop before handshake; registered addr stable until handshake.

## Test plan
- Defaults, write addr 4'h5 data 8'hA5 to zero-wait slaves -> only s_awvalid[1] rises, cycle 1; s_wdata 8'hA5 at s_wvalid[1]; m_bresp=0 at cycle 3; slaves 0/2 see no valid.
- Read addr 4'h9, slave 2 returns 8'h3C after 4 wait cycles with rresp 0 -> m_rdata=8'h3C, m_rvalid held until m_rready; next AR not accepted before.
- Write addr 4'hC (sel 3 >= N_SLAVES) -> no slave valid ever; m_bresp=2'b11 two cycles after AW. Read 4'hF -> m_rresp=2'b11, m_rdata=0.
- Concurrent write to 4'h1 and read from 4'h2 in same cycle -> both complete on slave 0 independently, correct data/resp.
- Backpressure: m_bready/m_rready low 5 cycles, slave response held stable, hub outputs stable, completes on release.
- Assert rst_n low during W_DATA -> all s_*valid low immediately, m_awready=1 after release, next write completes normally.
